// File: rtl/instr_fetch.sv
// instr_fetch: instruction fetch unit with a single outstanding memory
// request and a first-word fall-through instruction buffer.
//
// Ports:
//   clk, reset          clock, synchronous active-high reset
//   o_mem_valid         read request valid (held until i_mem_ready)
//   o_mem_address       read request address
//   i_mem_ready         memory accepts the request
//   i_mem_res_valid     read response valid
//   i_mem_res_data      read response data
//   o_valid             instruction available to decode
//   o_instr, o_pc       head-of-buffer instruction and its address
//   i_ready             decode accepts the instruction
//   i_redirect          flush the buffer and restart fetch
//   i_redirect_pc       restart address (low word-offset bits ignored)
//   o_stall_cnt         decode-starvation counter
//
// Build option: define FETCH_STALL_CNT_EN to implement o_stall_cnt,
// otherwise it is tied to zero.

module instr_fetch #(
    parameter int                         ADDRESS_WIDTH = 32,
    parameter int                         DATA_WIDTH    = 32,
    parameter logic [ADDRESS_WIDTH-1:0]   RESET_PC      = '0,
    parameter int                         FIFO_DEPTH    = 2
) (
    input  logic                     clk,
    input  logic                     reset,
    output logic                     o_mem_valid,
    output logic [ADDRESS_WIDTH-1:0] o_mem_address,
    input  logic                     i_mem_ready,
    input  logic                     i_mem_res_valid,
    input  logic [DATA_WIDTH-1:0]    i_mem_res_data,
    output logic                     o_valid,
    output logic [DATA_WIDTH-1:0]    o_instr,
    output logic [ADDRESS_WIDTH-1:0] o_pc,
    input  logic                     i_ready,
    input  logic                     i_redirect,
    input  logic [ADDRESS_WIDTH-1:0] i_redirect_pc,
    output logic [31:0]              o_stall_cnt
);

    localparam int STRIDE = DATA_WIDTH / 8;
    localparam int OFFS_W = $clog2(STRIDE);
    localparam int PTR_W  = $clog2(FIFO_DEPTH);
    localparam int CNT_W  = PTR_W + 1;

    localparam logic [ADDRESS_WIDTH-1:0] ALIGN_MASK =
        {ADDRESS_WIDTH{1'b1}} << OFFS_W;
    localparam logic [CNT_W-1:0] DEPTH_C = CNT_W'(FIFO_DEPTH);

    typedef enum logic [1:0] {
        S_IDLE,
        S_REQ,
        S_WAIT,
        S_DROP
    } state_e;

    state_e                   state_q, state_d;
    logic [ADDRESS_WIDTH-1:0] pc_q, pc_d;
    logic [ADDRESS_WIDTH-1:0] req_addr_q, req_addr_d;

    logic [DATA_WIDTH-1:0]    fifo_data_q [FIFO_DEPTH];
    logic [ADDRESS_WIDTH-1:0] fifo_pc_q   [FIFO_DEPTH];
    logic [PTR_W-1:0]         wr_ptr_q, rd_ptr_q;
    logic [CNT_W-1:0]         count_q, count_d;

    logic push;
    logic pop;

    assign o_mem_valid   = (state_q == S_REQ);
    assign o_mem_address = pc_q;

    assign o_valid = (count_q != '0);
    assign o_instr = fifo_data_q[rd_ptr_q];
    assign o_pc    = fifo_pc_q[rd_ptr_q];

    // A pop in the redirect cycle still counts as consumed by decode;
    // the flush below then empties whatever is left.
    assign pop  = o_valid && i_ready;
    assign push = (state_q == S_WAIT) && i_mem_res_valid && !i_redirect;

    assign count_d = count_q + CNT_W'(push) - CNT_W'(pop);

    always_comb begin
        state_d    = state_q;
        pc_d       = pc_q;
        req_addr_d = req_addr_q;
        if (i_redirect) begin
            pc_d = i_redirect_pc & ALIGN_MASK;
            unique case (state_q)
                // A request handshaking in this very cycle will still
                // return data, which must be drained.
                S_REQ:  state_d = i_mem_ready ? S_DROP : S_IDLE;
                // A response in the redirect cycle is the stale one;
                // nothing else is left to drain.
                S_WAIT,
                S_DROP: state_d = i_mem_res_valid ? S_IDLE : S_DROP;
                default: state_d = S_IDLE;
            endcase
        end else begin
            unique case (state_q)
                S_IDLE: begin
                    if (count_q < DEPTH_C) state_d = S_REQ;
                end
                S_REQ: begin
                    if (i_mem_ready) begin
                        state_d    = S_WAIT;
                        req_addr_d = pc_q;
                        pc_d       = pc_q + ADDRESS_WIDTH'(STRIDE);
                    end
                end
                S_WAIT: begin
                    if (i_mem_res_valid) begin
                        state_d = (count_d < DEPTH_C) ? S_REQ : S_IDLE;
                    end
                end
                S_DROP: begin
                    if (i_mem_res_valid) state_d = S_IDLE;
                end
                default: state_d = S_IDLE;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q    <= S_IDLE;
            pc_q       <= RESET_PC;
            req_addr_q <= RESET_PC;
        end else begin
            state_q    <= state_d;
            pc_q       <= pc_d;
            req_addr_q <= req_addr_d;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
            for (int i = 0; i < FIFO_DEPTH; i++) begin
                fifo_data_q[i] <= '0;
                fifo_pc_q[i]   <= RESET_PC;
            end
        end else if (i_redirect) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            if (push) begin
                fifo_data_q[wr_ptr_q] <= i_mem_res_data;
                fifo_pc_q[wr_ptr_q]   <= req_addr_q;
                wr_ptr_q              <= wr_ptr_q + PTR_W'(1);
            end
            if (pop) begin
                rd_ptr_q <= rd_ptr_q + PTR_W'(1);
            end
            count_q <= count_d;
        end
    end

`ifdef FETCH_STALL_CNT_EN
    logic [31:0] stall_cnt_q;

    always_ff @(posedge clk) begin
        if (reset) begin
            stall_cnt_q <= '0;
        end else if (i_ready && !o_valid && (stall_cnt_q != '1)) begin
            stall_cnt_q <= stall_cnt_q + 32'd1;
        end
    end

    assign o_stall_cnt = stall_cnt_q;
`else
    assign o_stall_cnt = '0;
`endif

endmodule

// File: tb/tb_instr_fetch.sv
// tb_instr_fetch: self-checking bench for instr_fetch with a
// latency-configurable memory model and a PC/instruction scoreboard.

module tb_instr_fetch;

    logic        clk;
    logic        reset;
    logic        o_mem_valid;
    logic [31:0] o_mem_address;
    logic        i_mem_ready;
    logic        i_mem_res_valid;
    logic [31:0] i_mem_res_data;
    logic        o_valid;
    logic [31:0] o_instr;
    logic [31:0] o_pc;
    logic        i_ready;
    logic        i_redirect;
    logic [31:0] i_redirect_pc;
    logic [31:0] o_stall_cnt;

    int tests = 0;
    int fails = 0;

    logic [31:0] exp_q [$];

    int          mem_lat;
    int          lat_cnt;
    logic [31:0] pend_addr;

    instr_fetch #(
        .ADDRESS_WIDTH (32),
        .DATA_WIDTH    (32),
        .RESET_PC      (32'h100),
        .FIFO_DEPTH    (2)
    ) dut (
        .clk             (clk),
        .reset           (reset),
        .o_mem_valid     (o_mem_valid),
        .o_mem_address   (o_mem_address),
        .i_mem_ready     (i_mem_ready),
        .i_mem_res_valid (i_mem_res_valid),
        .i_mem_res_data  (i_mem_res_data),
        .o_valid         (o_valid),
        .o_instr         (o_instr),
        .o_pc            (o_pc),
        .i_ready         (i_ready),
        .i_redirect      (i_redirect),
        .i_redirect_pc   (i_redirect_pc),
        .o_stall_cnt     (o_stall_cnt)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Memory: data word is the bitwise inverse of its address; the
    // response appears mem_lat cycles after the accepting edge.
    initial begin
        lat_cnt         = 0;
        pend_addr       = '0;
        i_mem_res_valid = 1'b0;
        i_mem_res_data  = '0;
    end

    always @(negedge clk) begin
        if (reset) begin
            lat_cnt         = 0;
            i_mem_res_valid = 1'b0;
        end else begin
            i_mem_res_valid = 1'b0;
            if (lat_cnt > 0) begin
                lat_cnt = lat_cnt - 1;
                if (lat_cnt == 0) begin
                    i_mem_res_valid = 1'b1;
                    i_mem_res_data  = ~pend_addr;
                end
            end
            if (o_mem_valid && i_mem_ready) begin
                lat_cnt   = mem_lat;
                pend_addr = o_mem_address;
            end
        end
    end

    // Scoreboard: each decode transfer pops the next expected PC.
    always @(negedge clk) begin
        logic [31:0] e;
        if (!reset && o_valid && i_ready && exp_q.size() > 0) begin
            e = exp_q.pop_front();
            tests++;
            if (o_pc !== e || o_instr !== ~e) begin
                fails++;
                $display("FAIL sb_pop: pc=%h instr=%h want pc=%h instr=%h",
                         o_pc, o_instr, e, ~e);
            end
        end
    end

    task automatic step(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic wait_drain(input int max, output bit ok);
        ok = 1'b0;
        for (int i = 0; i < max; i++) begin
            if (exp_q.size() == 0) begin
                ok = 1'b1;
                break;
            end
            step(1);
        end
        if (exp_q.size() == 0) ok = 1'b1;
    endtask

    task automatic wait_req(input int max, output bit ok);
        ok = 1'b0;
        for (int i = 0; i < max; i++) begin
            if (o_mem_valid) begin
                ok = 1'b1;
                break;
            end
            step(1);
        end
    endtask

    task automatic drain(input string name);
        bit ok;
        wait_drain(30, ok);
        tests++;
        if (!ok) begin
            fails++;
            $display("FAIL %s: %0d entries left, want 0", name, exp_q.size());
            exp_q.delete();
        end
    endtask

    task automatic test_reset();
        reset       = 1'b1;
        i_ready     = 1'b1;
        i_mem_ready = 1'b1;
        step(3);
        tests++;
        if (o_mem_valid !== 1'b0 || o_valid !== 1'b0) begin
            fails++;
            $display("FAIL rst_valid: mem_valid=%b valid=%b want 0 0",
                     o_mem_valid, o_valid);
        end
        tests++;
        if (o_mem_address !== 32'h100 || o_pc !== 32'h100) begin
            fails++;
            $display("FAIL rst_addr: addr=%h pc=%h want 100 100",
                     o_mem_address, o_pc);
        end
        tests++;
        if (o_instr !== 32'h0 || o_stall_cnt !== 32'h0) begin
            fails++;
            $display("FAIL rst_data: instr=%h stall=%0d want 0 0",
                     o_instr, o_stall_cnt);
        end
    endtask

    task automatic test_stream();
        int          n;
        logic [31:0] exp_stall;
`ifdef FETCH_STALL_CNT_EN
        exp_stall = 32'd3;
`else
        exp_stall = 32'd0;
`endif
        exp_q.delete();
        reset = 1'b0;
        exp_q.push_back(32'h100);
        exp_q.push_back(32'h104);
        exp_q.push_back(32'h108);
        step(2);
        tests++;
        if (o_valid !== 1'b0) begin
            fails++;
            $display("FAIL first_valid_early: valid=%b want 0", o_valid);
        end
        step(1);
        tests++;
        if (o_valid !== 1'b1) begin
            fails++;
            $display("FAIL first_valid: valid=%b want 1", o_valid);
        end
        tests++;
        if (o_stall_cnt !== exp_stall) begin
            fails++;
            $display("FAIL stall_cnt: got %0d want %0d", o_stall_cnt, exp_stall);
        end
        n = 0;
        repeat (6) begin
            @(negedge clk);
            if (o_valid && i_ready) n++;
        end
        tests++;
        if (n !== 3) begin
            fails++;
            $display("FAIL throughput: %0d transfers in 6 cycles want 3", n);
        end
        step(1);
        drain("stream_drain");
    endtask

    task automatic test_backpressure();
        int n;
        step(1);
        i_ready       = 1'b0;
        i_redirect    = 1'b1;
        i_redirect_pc = 32'h400;
        step(1);
        i_redirect = 1'b0;
        exp_q.delete();
        step(6);
        for (int c = 0; c < 4; c++) begin
            tests++;
            if (o_valid !== 1'b1 || o_pc !== 32'h400 ||
                o_instr !== 32'hFFFF_FBFF || o_mem_valid !== 1'b0) begin
                fails++;
                $display("FAIL hold_%0d: valid=%b pc=%h instr=%h mv=%b want 1 400 fffffbff 0",
                         c, o_valid, o_pc, o_instr, o_mem_valid);
            end
            step(1);
        end
        exp_q.push_back(32'h400);
        exp_q.push_back(32'h404);
        exp_q.push_back(32'h408);
        i_ready = 1'b1;
        n = 0;
        repeat (2) begin
            @(negedge clk);
            if (o_valid) n++;
        end
        @(negedge clk);
        tests++;
        if (n !== 2 || o_valid !== 1'b0) begin
            fails++;
            $display("FAIL buffered: %0d back-to-back then valid=%b want 2 then 0",
                     n, o_valid);
        end
        step(1);
        drain("bp_drain");
    endtask

    task automatic test_mem_stall();
        bit ok;
        step(1);
        i_mem_ready   = 1'b0;
        i_redirect    = 1'b1;
        i_redirect_pc = 32'h600;
        step(1);
        i_redirect = 1'b0;
        exp_q.delete();
        wait_req(10, ok);
        tests++;
        if (!ok) begin
            fails++;
            $display("FAIL stall_req: mem_valid=%b want 1", o_mem_valid);
        end
        for (int c = 0; c < 5; c++) begin
            tests++;
            if (o_mem_valid !== 1'b1 || o_mem_address !== 32'h600) begin
                fails++;
                $display("FAIL stall_hold_%0d: mv=%b addr=%h want 1 600",
                         c, o_mem_valid, o_mem_address);
            end
            step(1);
        end
        exp_q.push_back(32'h600);
        exp_q.push_back(32'h604);
        i_mem_ready = 1'b1;
        drain("stall_drain");
    endtask

    task automatic test_redirect_wait();
        bit ok;
        step(1);
        wait_req(10, ok);
        step(1);
        i_redirect    = 1'b1;
        i_redirect_pc = 32'h203;
        exp_q.delete();
        step(1);
        i_redirect = 1'b0;
        tests++;
        if (!ok || o_valid !== 1'b0) begin
            fails++;
            $display("FAIL redir_flush: valid=%b reqseen=%b want 0 1", o_valid, ok);
        end
        exp_q.push_back(32'h200);
        exp_q.push_back(32'h204);
        wait_req(10, ok);
        tests++;
        if (!ok || o_mem_address !== 32'h200) begin
            fails++;
            $display("FAIL redir_addr: addr=%h want 200", o_mem_address);
        end
        drain("redir_drain");
    endtask

    task automatic test_redirect_drop();
        bit ok;
        step(1);
        mem_lat = 3;
        wait_req(10, ok);
        step(1);
        i_redirect    = 1'b1;
        i_redirect_pc = 32'h300;
        exp_q.delete();
        step(1);
        tests++;
        if (!ok || o_valid !== 1'b0 || o_mem_valid !== 1'b0) begin
            fails++;
            $display("FAIL drop_enter: valid=%b mv=%b want 0 0", o_valid, o_mem_valid);
        end
        i_redirect_pc = 32'h313;
        step(1);
        i_redirect = 1'b0;
        mem_lat    = 1;
        tests++;
        if (o_mem_valid !== 1'b0) begin
            fails++;
            $display("FAIL drop_hold: mv=%b want 0", o_mem_valid);
        end
        exp_q.push_back(32'h310);
        exp_q.push_back(32'h314);
        drain("drop_drain");
    endtask

    task automatic test_wrap();
        step(1);
        i_redirect    = 1'b1;
        i_redirect_pc = 32'hFFFF_FFFF;
        exp_q.delete();
        step(1);
        i_redirect = 1'b0;
        exp_q.push_back(32'hFFFF_FFFC);
        exp_q.push_back(32'h0000_0000);
        exp_q.push_back(32'h0000_0004);
        drain("wrap_drain");
    endtask

    task automatic test_reset_mid();
        bit ok;
        step(1);
        mem_lat = 3;
        wait_req(10, ok);
        step(1);
        reset   = 1'b1;
        mem_lat = 1;
        exp_q.delete();
        step(1);
        tests++;
        if (!ok || o_valid !== 1'b0 || o_mem_valid !== 1'b0) begin
            fails++;
            $display("FAIL rst_mid: valid=%b mv=%b want 0 0", o_valid, o_mem_valid);
        end
        reset = 1'b0;
        exp_q.push_back(32'h100);
        exp_q.push_back(32'h104);
        step(1);
        tests++;
        if (o_mem_valid !== 1'b1 || o_mem_address !== 32'h100) begin
            fails++;
            $display("FAIL rst_mid_req: mv=%b addr=%h want 1 100",
                     o_mem_valid, o_mem_address);
        end
        drain("rst_mid_drain");
    endtask

    initial begin
        reset         = 1'b1;
        i_ready       = 1'b0;
        i_mem_ready   = 1'b0;
        i_redirect    = 1'b0;
        i_redirect_pc = '0;
        mem_lat       = 1;
        test_reset();
        test_stream();
        test_backpressure();
        test_mem_stall();
        test_redirect_wait();
        test_redirect_drop();
        test_wrap();
        test_reset_mid();
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, want finish");
        $fatal(1);
    end

endmodule
